// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between the bridge master port and the memory slave.
// 32-bit addresses, 64-bit data, single ID.
interface axi_mem_slave_if;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic [2:0]  S_AXI_AWSIZE;
  logic [1:0]  S_AXI_AWBURST;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [63:0] S_AXI_WDATA;
  logic [7:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic [2:0]  S_AXI_ARSIZE;
  logic [1:0]  S_AXI_ARBURST;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [63:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
    output S_AXI_AWBURST, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
    output S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
    output S_AXI_ARBURST, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
    input  S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
    input  S_AXI_AWBURST, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
    input  S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
    input  S_AXI_ARBURST, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
    output S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 64-bit memory slave, serialized INCR bursts, WSTRB byte enables.
// Define AXI_MEM_SLAVE_DECERR_EN to answer out-of-window bursts with DECERR.
module axi_mem_slave #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic            S_AXI_ACLK,
  input logic            S_AXI_ARESETN,
  axi_mem_slave_if.slave s_axi
);
  localparam int unsigned AW = DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t        state;
  logic [63:0]   mem [2**AW];
  logic [AW-1:0] ptr;
  logic [7:0]    cnt;
  logic          err;
  logic          issuing;
  logic [63:0]   ob_data [2];
  logic [1:0]    ob_last;
  logic          rd_idx;
  logic          wr_idx;
  logic [1:0]    fill;

  logic aw_hs, ar_hs, w_hs, r_hs, issue;
  logic aw_err, ar_err;
  logic rvalid;

  assign rvalid = (fill != 2'd0);
  assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign r_hs   = rvalid && s_axi.S_AXI_RREADY;
  // A slot is free if the buffer is not full or its head leaves now.
  assign issue  = issuing && ((fill != 2'd2) || r_hs);

  assign s_axi.S_AXI_AWREADY = (state == IDLE);
  assign s_axi.S_AXI_ARREADY = (state == IDLE) &&
                               !s_axi.S_AXI_AWVALID;
  assign s_axi.S_AXI_WREADY  = (state == WDATA);
  assign s_axi.S_AXI_BVALID  = (state == WRESP);
  assign s_axi.S_AXI_BRESP   = (state == WRESP && err) ?
                               2'b11 : 2'b00;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = ob_data[rd_idx];
  assign s_axi.S_AXI_RLAST   = rvalid && ob_last[rd_idx];
  assign s_axi.S_AXI_RRESP   = (rvalid && err) ? 2'b11 : 2'b00;

`ifdef AXI_MEM_SLAVE_DECERR_EN
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd8 << AW);

  function automatic logic out_of_win(input logic [31:0] a);
    return ({1'b0, a} < WIN_LO) || ({1'b0, a} >= WIN_HI);
  endfunction

  assign aw_err = out_of_win(s_axi.S_AXI_AWADDR);
  assign ar_err = out_of_win(s_axi.S_AXI_ARADDR);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR,
                       s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST,
                       s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARSIZE,
                       s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_WLAST, BASE_ADDR};

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_hs && !err) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi.S_AXI_WSTRB[b])
          mem[ptr][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      issuing    <= 1'b0;
      ob_data[0] <= '0;
      ob_data[1] <= '0;
      ob_last    <= '0;
      rd_idx     <= 1'b0;
      wr_idx     <= 1'b0;
      fill       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (aw_hs) begin
            ptr   <= s_axi.S_AXI_AWADDR[AW+2:3];
            cnt   <= s_axi.S_AXI_AWLEN;
            err   <= aw_err;
            state <= WDATA;
          end else if (ar_hs) begin
            ptr     <= s_axi.S_AXI_ARADDR[AW+2:3];
            cnt     <= s_axi.S_AXI_ARLEN;
            err     <= ar_err;
            issuing <= 1'b1;
            state   <= RDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            ptr <= ptr + 1'b1;
            if (cnt == '0) state <= WRESP;
            else           cnt   <= cnt - 1'b1;
          end
        end
        WRESP: begin
          if (s_axi.S_AXI_BREADY) state <= IDLE;
        end
        RDATA: begin
          // Synchronous read lands straight in the output buffer slot.
          if (issue) begin
            ob_data[wr_idx] <= err ? '0 : mem[ptr];
            ob_last[wr_idx] <= (cnt == '0);
            wr_idx          <= ~wr_idx;
            ptr             <= ptr + 1'b1;
            if (cnt == '0) issuing <= 1'b0;
            else           cnt     <= cnt - 1'b1;
          end
          if (r_hs) begin
            rd_idx <= ~rd_idx;
            if (ob_last[rd_idx]) state <= IDLE;
          end
          fill <= fill + {1'b0, issue} - {1'b0, r_hs};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: table vectors, corner sequences
// and random bursts against a word-array reference model.
`timescale 1ns/1ps
module tb_axi_mem_slave;
  localparam int DL    = 4;
  localparam int WORDS = 16;
  localparam int LIMIT = 2000;
`ifdef AXI_MEM_SLAVE_DECERR_EN
  localparam logic [31:0] BASE = 32'h0000_1000;
`else
  localparam logic [31:0] BASE = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_slave_if bus();

  axi_mem_slave #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] model [WORDS];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic [63:0] last_rdata;

  typedef struct {
    logic [31:0] off;
    logic [63:0] d;
    logic [7:0]  s;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit oow(input logic [31:0] a);
`ifdef AXI_MEM_SLAVE_DECERR_EN
    return (a < BASE) || (a >= BASE + 32'(8 * WORDS));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 3) % WORDS);
  endfunction

  // No grant may be offered while a transaction is in flight.
  always @(negedge clk) begin
    if (rst_n && (bus.S_AXI_WREADY || bus.S_AXI_BVALID ||
                  bus.S_AXI_RVALID)) begin
      checks++;
      if (bus.S_AXI_AWREADY || bus.S_AXI_ARREADY) begin
        errors++;
        $display("FAIL busy_ready: aw=%b ar=%b expected 0 0",
                 bus.S_AXI_AWREADY, bus.S_AXI_ARREADY);
      end
    end
  end

  task automatic wr_burst(input logic [31:0] addr, input int len,
                          input bit rnd_gap);
    int n;
    int k;
    bit hs;
    bit first;
    logic [1:0] exp_resp;
    exp_resp = oow(addr) ? 2'b11 : 2'b00;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWLEN   = len[7:0];
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = bus.S_AXI_AWREADY;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < LIMIT);
    bus.S_AXI_AWVALID = 1'b0;
    chk("aw_accept", 64'(hs), 64'd1);
    k = 0;
    n = 0;
    first = 1'b1;
    while (k <= len && n < LIMIT) begin
      if (rnd_gap && $urandom_range(0, 3) == 0) begin
        bus.S_AXI_WVALID = 1'b0;
      end else begin
        bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_WDATA  = wd[k];
        bus.S_AXI_WSTRB  = ws[k];
        bus.S_AXI_WLAST  = (k == len);
      end
      @(negedge clk);
      if (first) chk("wready_t1", 64'(bus.S_AXI_WREADY), 64'd1);
      first = 1'b0;
      hs = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge clk); #1;
      if (hs) begin
        if (!oow(addr)) begin
          for (int b = 0; b < 8; b++)
            if (ws[k][b])
              model[(widx(addr) + k) % WORDS][8*b +: 8] = wd[k][8*b +: 8];
        end
        k++;
      end
      n++;
    end
    bus.S_AXI_WVALID = 1'b0;
    chk("w_beats_done", 64'(k), 64'(len + 1));
    @(negedge clk);
    chk("bvalid_u1", 64'(bus.S_AXI_BVALID), 64'd1);
    chk("bresp", 64'(bus.S_AXI_BRESP), 64'(exp_resp));
    @(posedge clk); #1;
    @(negedge clk);
    chk("awready_u2", 64'(bus.S_AXI_AWREADY), 64'd1);
    chk("bvalid_once", 64'(bus.S_AXI_BVALID), 64'd0);
    @(posedge clk); #1;
  endtask

  // mode 0: RREADY high, 1: toggling, 2: random.
  task automatic rd_burst(input logic [31:0] addr, input int len,
                          input int mode, input bit granted);
    int n;
    int beat;
    bit hs;
    bit held;
    logic [63:0] hd;
    logic hl;
    logic [63:0] exp;
    logic [1:0] exp_resp;
    exp_resp = oow(addr) ? 2'b11 : 2'b00;
    if (!granted) begin
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARLEN   = len[7:0];
      bus.S_AXI_ARVALID = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        hs = bus.S_AXI_ARREADY;
        @(posedge clk); #1;
        n++;
      end while (!hs && n < LIMIT);
      chk("ar_accept", 64'(hs), 64'd1);
    end
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    chk("rvalid_t1", 64'(bus.S_AXI_RVALID), 64'd0);
    @(posedge clk); #1;
    beat = 0;
    n = 0;
    held = 1'b0;
    while (beat <= len && n < LIMIT) begin
      case (mode)
        0:       bus.S_AXI_RREADY = 1'b1;
        1:       bus.S_AXI_RREADY = (n % 2 == 1);
        default: bus.S_AXI_RREADY = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (n == 0) chk("rvalid_t2", 64'(bus.S_AXI_RVALID), 64'd1);
      if (mode == 0) chk("r_b2b", 64'(bus.S_AXI_RVALID), 64'd1);
      if (held) begin
        chk("r_hold_data", bus.S_AXI_RDATA, hd);
        chk("r_hold_last", 64'(bus.S_AXI_RLAST), 64'(hl));
      end
      held = 1'b0;
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        exp = oow(addr) ? 64'd0 : model[(widx(addr) + beat) % WORDS];
        chk("rdata", bus.S_AXI_RDATA, exp);
        chk("rlast", 64'(bus.S_AXI_RLAST), 64'(beat == len));
        chk("rresp", 64'(bus.S_AXI_RRESP), 64'(exp_resp));
        last_rdata = bus.S_AXI_RDATA;
        beat++;
      end else if (bus.S_AXI_RVALID) begin
        held = 1'b1;
        hd = bus.S_AXI_RDATA;
        hl = bus.S_AXI_RLAST;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.S_AXI_RREADY = 1'b0;
    chk("r_beats_done", 64'(beat), 64'(len + 1));
    @(negedge clk);
    chk("idle_after_r", 64'(bus.S_AXI_ARREADY), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit hs;
    logic [31:0] a;
    int l;

    tbl[0] = '{32'h10, 64'h1122334455667788, 8'hFF,
               64'h1122334455667788};
    tbl[1] = '{32'h18, 64'hFFFFFFFFFFFFFFFF, 8'hFF,
               64'hFFFFFFFFFFFFFFFF};
    tbl[2] = '{32'h18, 64'h0000000000000000, 8'h0F,
               64'hFFFFFFFF00000000};
    tbl[3] = '{32'h18, 64'h0123456789ABCDEF, 8'h81,
               64'h01FFFFFF000000EF};
    tbl[4] = '{32'h20, 64'h5555555555555555, 8'hFF,
               64'h5555555555555555};
    tbl[5] = '{32'h20, 64'hAAAAAAAAAAAAAAAA, 8'h00,
               64'h5555555555555555};

    bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWLEN = '0;
    bus.S_AXI_AWSIZE = 3'd3; bus.S_AXI_AWBURST = 2'b01;
    bus.S_AXI_AWPROT = '0;  bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;   bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARLEN = '0;
    bus.S_AXI_ARSIZE = 3'd3; bus.S_AXI_ARBURST = 2'b01;
    bus.S_AXI_ARPROT = '0;  bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    #12;
    chk("rst_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
    chk("rst_arready", 64'(bus.S_AXI_ARREADY), 64'd1);
    chk("rst_wready", 64'(bus.S_AXI_WREADY), 64'd0);
    chk("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
    chk("rst_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
    chk("rst_rlast", 64'(bus.S_AXI_RLAST), 64'd0);
    chk("rst_rdata", bus.S_AXI_RDATA, 64'd0);
    chk("rst_bresp", 64'(bus.S_AXI_BRESP), 64'd0);
    chk("rst_rresp", 64'(bus.S_AXI_RRESP), 64'd0);
    bus.S_AXI_AWVALID = 1'b1;
    #1;
    chk("rst_ar_blocked", 64'(bus.S_AXI_ARREADY), 64'd0);
    bus.S_AXI_AWVALID = 1'b0;
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < WORDS; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = 8'hFF;
    end
    wr_burst(BASE, WORDS - 1, 1'b0);
    rd_burst(BASE, WORDS - 1, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      wd[0] = tbl[i].d;
      ws[0] = tbl[i].s;
      wr_burst(BASE + tbl[i].off, 0, 1'b0);
      rd_burst(BASE + tbl[i].off, 0, 0, 1'b0);
      chk($sformatf("tbl%0d", i), last_rdata, tbl[i].exp);
    end

    for (int i = 0; i < 8; i++) begin
      wd[i] = 64'(i);
      ws[i] = 8'hFF;
    end
    wr_burst(BASE + 32'h40, 7, 1'b0);
    rd_burst(BASE + 32'h40, 7, 1, 1'b0);
    chk("burst_last", last_rdata, 64'd7);

    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = 8'hFF;
    end
    wr_burst(BASE + 32'h70, 3, 1'b0);
    rd_burst(BASE + 32'h70, 3, 2, 1'b0);
    rd_burst(BASE + 32'h08, 0, 0, 1'b0);
    chk("wrap_word1", last_rdata, wd[3]);

    // Write and read requested together; the read waits for the write.
    wd[0] = 64'hDEADBEEFCAFEF00D;
    ws[0] = 8'hFF;
    bus.S_AXI_ARADDR  = BASE + 32'h28;
    bus.S_AXI_ARLEN   = 8'd0;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_AWADDR  = BASE + 32'h28;
    bus.S_AXI_AWVALID = 1'b1;
    #1;
    chk("arb_aw_first", 64'(bus.S_AXI_AWREADY), 64'd1);
    chk("arb_ar_wait", 64'(bus.S_AXI_ARREADY), 64'd0);
    wr_burst(BASE + 32'h28, 0, 1'b0);
    rd_burst(BASE + 32'h28, 0, 0, 1'b1);
    chk("arb_new_data", last_rdata, 64'hDEADBEEFCAFEF00D);

    // Reset after three of eight beats.
    bus.S_AXI_AWADDR  = BASE + 32'h40;
    bus.S_AXI_AWLEN   = 8'd7;
    bus.S_AXI_AWVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    k = 0;
    for (int i = 0; i < LIMIT && k < 3; i++) begin
      wd[k] = {$urandom, $urandom};
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_WDATA  = wd[k];
      bus.S_AXI_WSTRB  = 8'hFF;
      @(negedge clk);
      hs = bus.S_AXI_WREADY;
      @(posedge clk); #1;
      if (hs) begin
        model[(8 + k) % WORDS] = wd[k];
        k++;
      end
    end
    rst_n = 1'b0;
    #1;
    chk("mid_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
    chk("mid_wready", 64'(bus.S_AXI_WREADY), 64'd0);
    chk("mid_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
    chk("mid_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
    chk("mid_rlast", 64'(bus.S_AXI_RLAST), 64'd0);
    chk("mid_rdata", bus.S_AXI_RDATA, 64'd0);
    bus.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wd[0] = 64'h0F0F0F0F0F0F0F0F;
    ws[0] = 8'hFF;
    wr_burst(BASE, 0, 1'b0);
    rd_burst(BASE + 32'h40, 7, 2, 1'b0);

    for (int i = 0; i < 25; i++) begin
      l = $urandom_range(0, 20);
      a = BASE + 32'($urandom_range(0, 127) << 3) +
          32'($urandom_range(0, 7));
      for (int j = 0; j <= l; j++) begin
        wd[j] = {$urandom, $urandom};
        ws[j] = 8'($urandom);
      end
      wr_burst(a, l, 1'b1);
      l = $urandom_range(0, 20);
      a = BASE + 32'($urandom_range(0, 127) << 3);
      rd_burst(a, l, 2, 1'b0);
    end

`ifdef AXI_MEM_SLAVE_DECERR_EN
    for (int j = 0; j < 2; j++) begin
      wd[j] = 64'h1234123412341234;
      ws[j] = 8'hFF;
    end
    wr_burst(32'h0, 1, 1'b0);
    rd_burst(32'h0, 2, 0, 1'b0);
    rd_burst(BASE, WORDS - 1, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
